// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for the Sobel kernel: two row line buffers plus a 3x3 shift window.
// Optional macro SOBEL_WIN_OUTREG_EN adds one extra output register stage (latency 2 instead of 1).
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int CW         = $clog2(IMG_WIDTH),
  parameter int RW         = $clog2(IMG_HEIGHT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    pixel_in,
  input  logic          pixel_valid,
  input  logic          sof,
  output logic [7:0]    pixel_00,
  output logic [7:0]    pixel_01,
  output logic [7:0]    pixel_02,
  output logic [7:0]    pixel_10,
  output logic [7:0]    pixel_11,
  output logic [7:0]    pixel_12,
  output logic [7:0]    pixel_20,
  output logic [7:0]    pixel_21,
  output logic [7:0]    pixel_22,
  output logic          window_valid,
  output logic [RW-1:0] center_row,
  output logic [CW-1:0] center_col,
  output logic          frame_done
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t        state_q;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic [CW-1:0] col_q, col_d, cur_col;
  logic          accept, last_px, win_ok;

  logic [7:0] lb0 [IMG_WIDTH];
  logic [7:0] lb1 [IMG_WIDTH];

  logic [7:0]    win_q [3][3];
  logic          wvalid_q, done_q;
  logic [RW-1:0] crow_q;
  logic [CW-1:0] ccol_q;

  // sof overrides the counters in either state, so position is resolved before use
  always_comb begin
    accept  = pixel_valid && (sof || (state_q == S_ACTIVE));
    cur_row = sof ? '0 : row_q;
    cur_col = sof ? '0 : col_q;
    last_px = (cur_row == RW'(IMG_HEIGHT - 1)) && (cur_col == CW'(IMG_WIDTH - 1));
    win_ok  = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    row_d   = cur_row;
    col_d   = cur_col + CW'(1);
    if (cur_col == CW'(IMG_WIDTH - 1)) begin
      col_d = '0;
      row_d = cur_row + RW'(1);
    end
    if (last_px) begin
      row_d = '0;
      col_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[cur_col] <= lb0[cur_col];
      lb0[cur_col] <= pixel_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      row_q    <= '0;
      col_q    <= '0;
      win_q    <= '{default: '0};
      wvalid_q <= 1'b0;
      done_q   <= 1'b0;
      crow_q   <= '0;
      ccol_q   <= '0;
    end else begin
      wvalid_q <= 1'b0;
      done_q   <= 1'b0;
      if (accept) begin
        win_q[0][0] <= win_q[0][1];
        win_q[0][1] <= win_q[0][2];
        win_q[0][2] <= lb1[cur_col];
        win_q[1][0] <= win_q[1][1];
        win_q[1][1] <= win_q[1][2];
        win_q[1][2] <= lb0[cur_col];
        win_q[2][0] <= win_q[2][1];
        win_q[2][1] <= win_q[2][2];
        win_q[2][2] <= pixel_in;
        wvalid_q    <= win_ok;
        if (win_ok) begin
          crow_q <= cur_row - RW'(1);
          ccol_q <= cur_col - CW'(1);
        end
        row_q <= row_d;
        col_q <= col_d;
        if (last_px) begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end else begin
          state_q <= S_ACTIVE;
        end
      end
    end
  end

`ifdef SOBEL_WIN_OUTREG_EN
  logic [7:0]    owin_q [3][3];
  logic          owvalid_q, odone_q;
  logic [RW-1:0] ocrow_q;
  logic [CW-1:0] occol_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owin_q    <= '{default: '0};
      owvalid_q <= 1'b0;
      odone_q   <= 1'b0;
      ocrow_q   <= '0;
      occol_q   <= '0;
    end else begin
      owin_q    <= win_q;
      owvalid_q <= wvalid_q;
      odone_q   <= done_q;
      ocrow_q   <= crow_q;
      occol_q   <= ccol_q;
    end
  end

  assign pixel_00     = owin_q[0][0];
  assign pixel_01     = owin_q[0][1];
  assign pixel_02     = owin_q[0][2];
  assign pixel_10     = owin_q[1][0];
  assign pixel_11     = owin_q[1][1];
  assign pixel_12     = owin_q[1][2];
  assign pixel_20     = owin_q[2][0];
  assign pixel_21     = owin_q[2][1];
  assign pixel_22     = owin_q[2][2];
  assign window_valid = owvalid_q;
  assign frame_done   = odone_q;
  assign center_row   = ocrow_q;
  assign center_col   = occol_q;
`else
  assign pixel_00     = win_q[0][0];
  assign pixel_01     = win_q[0][1];
  assign pixel_02     = win_q[0][2];
  assign pixel_10     = win_q[1][0];
  assign pixel_11     = win_q[1][1];
  assign pixel_12     = win_q[1][2];
  assign pixel_20     = win_q[2][0];
  assign pixel_21     = win_q[2][1];
  assign pixel_22     = win_q[2][2];
  assign window_valid = wvalid_q;
  assign frame_done   = done_q;
  assign center_row   = crow_q;
  assign center_col   = ccol_q;
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Self-checking bench for sobel_window_gen (W=8, H=6) against an image-array reference model.
module tb_sobel_window_gen;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    pixel_in = '0;
  logic          pixel_valid = 1'b0;
  logic          sof = 1'b0;
  logic [7:0]    pixel_00, pixel_01, pixel_02, pixel_10, pixel_11, pixel_12, pixel_20, pixel_21, pixel_22;
  logic          window_valid, frame_done;
  logic [RW-1:0] center_row;
  logic [CW-1:0] center_col;

  sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid), .sof(sof),
    .pixel_00(pixel_00), .pixel_01(pixel_01), .pixel_02(pixel_02),
    .pixel_10(pixel_10), .pixel_11(pixel_11), .pixel_12(pixel_12),
    .pixel_20(pixel_20), .pixel_21(pixel_21), .pixel_22(pixel_22),
    .window_valid(window_valid), .center_row(center_row), .center_col(center_col),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int win_cnt = 0;
  int done_cnt = 0;
  bit ramp_mode = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the frame is an image array; a window is read straight out of it.
  typedef struct {
    bit valid;
    bit done;
    bit known;
    int cr;
    int cc;
    int win[3][3];
  } obs_t;

  int   img[H][W];
  bit   m_act;
  int   m_r, m_c;
  obs_t m, e;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act = 0; m_r = 0; m_c = 0;
      m = '{valid: 0, done: 0, known: 1, cr: 0, cc: 0, win: '{default: 0}};
      e = m;
    end else begin
`ifdef SOBEL_WIN_OUTREG_EN
      e = m;
`endif
      m.valid = 0;
      m.done  = 0;
      if (pixel_valid && (sof || m_act)) begin
        int r, c;
        r = sof ? 0 : m_r;
        c = sof ? 0 : m_c;
        img[r][c] = pixel_in;
        if (r >= 2 && c >= 2) begin
          m.valid = 1;
          m.known = 1;
          m.cr = r - 1;
          m.cc = c - 1;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              m.win[i][j] = img[r-2+i][c-2+j];
        end else begin
          m.known = 0;
        end
        if (r == H-1 && c == W-1) begin
          m.done = 1; m_act = 0; m_r = 0; m_c = 0;
        end else begin
          m_act = 1;
          m_c = (c == W-1) ? 0 : c + 1;
          m_r = (c == W-1) ? r + 1 : r;
        end
      end
`ifndef SOBEL_WIN_OUTREG_EN
      e = m;
`endif
    end
  end

  always @(negedge clk) begin
    int dw[3][3];
    dw = '{'{pixel_00, pixel_01, pixel_02}, '{pixel_10, pixel_11, pixel_12}, '{pixel_20, pixel_21, pixel_22}};
    if (window_valid) win_cnt++;
    if (frame_done) done_cnt++;
    chk("window_valid", window_valid, e.valid);
    chk("frame_done", frame_done, e.done);
    if (e.valid) begin
      chk("center_row", center_row, e.cr);
      chk("center_col", center_col, e.cc);
    end
    if (e.known)
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          chk($sformatf("pixel_%0d%0d", i, j), dw[i][j], e.win[i][j]);
    if (ramp_mode && e.valid && e.cr == 1 && e.cc == 1) begin
      chk("first_win_p00", pixel_00, 0);
      chk("first_win_p11", pixel_11, 9);
      chk("first_win_p22", pixel_22, 18);
    end
    if (ramp_mode && e.valid && e.cr == 4 && e.cc == 6) begin
      chk("last_win_p22", pixel_22, 47);
      chk("last_win_done", frame_done, 1);
    end
  end

  task automatic push(input bit v, input bit s, input logic [7:0] p);
    pixel_valid = v; sof = s; pixel_in = p;
    @(posedge clk); #2;
    pixel_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic pix(input logic [7:0] p, input bit s, input int gapmax);
    int g;
    g = (gapmax > 0) ? $urandom_range(gapmax, 0) : 0;
    for (int k = 0; k < g; k++) push(1'b0, 1'b0, 8'($urandom));
    push(1'b1, s, p);
  endtask

  task automatic frame(input int gapmax, input bit randpix);
    int base_w, base_d;
    base_w = 0; base_d = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        pix(randpix ? 8'($urandom) : 8'(8*r + c), (r == 0 && c == 0), gapmax);
        if (r == 0 && c == 2) begin
          base_w = win_cnt; base_d = done_cnt;
        end
      end
    repeat (4) push(1'b0, 1'b0, 8'h00);
    chk("frame_window_count", win_cnt - base_w, (W-2)*(H-2));
    chk("frame_done_count", done_cnt - base_d, 1);
  endtask

  task automatic partial(input int stop_r, input int stop_c);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r < stop_r || (r == stop_r && c < stop_c))
          pix(8'(8*r + c), (r == 0 && c == 0), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("reset_window_valid", window_valid, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_p00", pixel_00, 0);
    chk("reset_p22", pixel_22, 0);
    chk("reset_center_row", center_row, 0);
    chk("reset_center_col", center_col, 0);
    reset = 1'b0;
    push(1'b0, 1'b0, 8'h00);

    frame(0, 1'b0);
    frame(3, 1'b0);

    for (int k = 0; k < 12; k++) push(1'b1, 1'b0, 8'hAA);
    frame(0, 1'b0);

    partial(3, 4);
    frame(0, 1'b0);

    partial(4, 3);
    pixel_valid = 1'b1; sof = 1'b0; pixel_in = 8'(8*4 + 3);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_window_valid", window_valid, 0);
    chk("async_rst_p11", pixel_11, 0);
    chk("async_rst_p22", pixel_22, 0);
    chk("async_rst_center_col", center_col, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    pixel_valid = 1'b0;
    for (int k = 0; k < 10; k++) push(1'b1, 1'b0, 8'($urandom));
    frame(0, 1'b0);

    ramp_mode = 1'b0;
    frame(2, 1'b1);
    frame(0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 neighbourhood generator directly upstream of the Sobel kernel stage. Accepts a raster-order 8-bit grayscale pixel stream, buffers the two previous image rows in on-chip line buffers, and presents a registered 3x3 window on the nine `pixel_rc` outputs that feed the kernel's identically named inputs. One window is emitted per accepted pixel once the window is fully inside the frame (interior centres only), with the centre coordinates alongside.

## Interface
- `IMG_WIDTH`, 640, pixels per row (≥3)
- `IMG_HEIGHT`, 480, rows per frame (≥3)
- `CW`, `$clog2(IMG_WIDTH)`, column counter width (derived)
- `RW`, `$clog2(IMG_HEIGHT)`, row counter width (derived)

- `clk`  in  1  single clock; all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `pixel_in`  in  8  input pixel, unsigned grayscale
- `pixel_valid`  in  1  `pixel_in` accepted this cycle when high
- `sof`  in  1  start of frame; qualifies the accepted pixel as (row 0, col 0); ignored unless `pixel_valid`
- `pixel_00`..`pixel_22`  out  8 each  window, row-major; `pixel_00` top-left (oldest row, oldest column), `pixel_22` bottom-right (newest pixel)
- `window_valid`  out  1  window outputs and centre coords valid this cycle
- `center_row`  out  RW  row of `pixel_11`
- `center_col`  out  CW  column of `pixel_11`
- `frame_done`  out  1  one-cycle pulse after the last pixel of a frame is accepted

## Operation
- FSM states: `S_IDLE`, `S_ACTIVE`.
  - `S_IDLE`: accepted pixels without `sof` are dropped (no buffer write, no counter change). Accepted pixel with `sof` → treated as (0,0), go to `S_ACTIVE`.
  - `S_ACTIVE`: every accepted pixel processed at (row, col); col increments, wraps W-1→0 with row increment. Accepted pixel at (H-1, W-1) → `frame_done` pulse, go to `S_IDLE`, counters cleared.
  - `sof` with accepted pixel while `S_ACTIVE`: frame restart; that pixel becomes (0,0); counters forced; line buffer contents kept (stale rows are never exposed, see validity rule).
- Line buffers: `lb0` (previous row), `lb1` (row before that), IMG_WIDTH x 8 each, register arrays, combinational read at index col. Not reset.
- Per accepted pixel at (r,c):
  - new column = {`lb1[c]`, `lb0[c]`, `pixel_in`} (top, mid, bottom).
  - window shifts left: column 0 ← column 1, column 1 ← column 2, column 2 ← new column.
  - `lb1[c]` ← `lb0[c]`, `lb0[c]` ← `pixel_in`.
- Validity: window marked valid iff r ≥ 2 and c ≥ 2; then `center_row` = r-1, `center_col` = c-1. Windows straddling a row wrap (c < 2) or using pre-frame rows (r < 2) are never flagged valid. Yields exactly (W-2)(H-2) valid windows per frame.
- Cycles with `pixel_valid` low: no state change; `window_valid` drops to 0; window outputs hold.
- No backpressure: downstream kernel is combinational and always ready.

## Timing
- Reset values: all `pixel_rc` = 0, `window_valid` = 0, `center_row` = 0, `center_col` = 0, `frame_done` = 0, state `S_IDLE`, counters 0.
- Latency (macro off): pixel accepted at edge N → window containing it as `pixel_22` and `window_valid` visible after edge N (one register stage).
- `frame_done` asserts in the same cycle as the last window's `window_valid`.
- Reset mid-frame: immediate (asynchronous) return to reset values; next frame requires `sof`.
- Throughput: one pixel per clock sustained.

## Configuration
- `SOBEL_WIN_OUTREG_EN`: defined → extra output register stage on all outputs (`pixel_rc`, `window_valid`, `center_*`, `frame_done`); latency 2 cycles, timing isolation from the kernel adder tree. Undefined → latency 1 as above. Reset values identical in both builds.

## Test plan
- W=8,H=6, ramp `pixel_in`=8r+c, continuous valid, `sof` on first → first `window_valid` one cycle after pixel (2,2): `pixel_00`=0, `pixel_11`=9, `pixel_22`=18, centre (1,1); exactly 24 valid windows; last window `pixel_22`=47, centre (4,6), coincident with single `frame_done` pulse.
- Same frame with random `pixel_valid` gaps → identical valid-window sequence, `window_valid` low during gaps, outputs held.
- Pixels streamed in `S_IDLE` without `sof` (values 0xAA) then normal frame → no valid windows or `frame_done` from the 0xAA pixels; frame output matches first test.
- `sof` reasserted at (3,4) of a frame, then full ramp frame → no valid window until new (2,2); no `frame_done` for aborted frame; 24 windows after.
- `reset` asserted mid-frame at (4,3) → all outputs 0 immediately; subsequent pixels ignored until `sof`; following frame correct.
- Build with `SOBEL_WIN_OUTREG_EN` → first test sequence reproduced, each output delayed by exactly one extra cycle.
